// File: rtl/fetch_unit.sv
// Raisin64 instruction fetch: a 16-halfword circular buffer fed by aligned 64-bit reads,
// presenting a 4-halfword instruction window at the current PC.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] fe_inst,
    output logic        fe_inst_valid,
    output logic [63:0] fe_pc,
    input  logic        fe_advance16,
    input  logic        fe_advance32,
    input  logic        fe_advance64,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [63:0] imem_data
);
    typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

    state_e      state_q;
    logic [15:0] slots_q [16];
    logic [3:0]  rd_q;
    logic [3:0]  wr_q;
    logic [4:0]  count_q;
    logic [63:0] pc_q;
    logic [63:0] fetch_addr_q;
    logic [63:0] addr_q;
    logic [1:0]  skip_q;
    logic        req_q;

    logic [2:0]  adv_n;
    logic [2:0]  wr_cnt;
    logic        ack_write;
    logic [3:0]  wr_en;
    logic [3:0]  wr_idx [4];
    logic        unused_pc_lsb;

    assign unused_pc_lsb = redirect_pc[0];

    assign fe_inst_valid = (count_q >= 5'd4);
    assign fe_inst = {slots_q[rd_q], slots_q[rd_q + 4'd1],
                      slots_q[rd_q + 4'd2], slots_q[rd_q + 4'd3]};
    assign fe_pc     = pc_q;
    assign imem_req  = req_q;
    assign imem_addr = addr_q;

    always_comb begin
        adv_n = 3'd0;
        if (fe_inst_valid) begin
            if (fe_advance64) begin
                adv_n = 3'd4;
            end else if (fe_advance32) begin
                adv_n = 3'd2;
            end else if (fe_advance16) begin
                adv_n = 3'd1;
            end
        end
    end

    // Only a live request's ack fills the buffer; redirect discards the data of the same cycle.
    always_comb begin
        ack_write = !rst && (state_q == StReq) && imem_ack && !redirect;
        wr_cnt    = ack_write ? (3'd4 - {1'b0, skip_q}) : 3'd0;
        wr_en     = 4'b0;
        for (int j = 0; j < 4; j++) begin
            wr_en[j]  = ack_write && (2'(j) >= skip_q);
            wr_idx[j] = wr_q + 4'(j) - {2'b00, skip_q};
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (wr_en[j]) begin
                slots_q[wr_idx[j]] <= imem_data[63 - 16*j -: 16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            req_q        <= 1'b0;
            addr_q       <= {RESET_PC[63:3], 3'b000};
            fetch_addr_q <= {RESET_PC[63:3], 3'b000};
            pc_q         <= {RESET_PC[63:1], 1'b0};
            rd_q         <= 4'd0;
            wr_q         <= 4'd0;
            count_q      <= 5'd0;
            skip_q       <= RESET_PC[2:1];
        end else begin
            if (redirect) begin
                rd_q         <= 4'd0;
                wr_q         <= 4'd0;
                count_q      <= 5'd0;
                pc_q         <= {redirect_pc[63:1], 1'b0};
                fetch_addr_q <= {redirect_pc[63:3], 3'b000};
                skip_q       <= redirect_pc[2:1];
            end else begin
                rd_q    <= rd_q + {1'b0, adv_n};
                wr_q    <= wr_q + {1'b0, wr_cnt};
                count_q <= count_q + {2'b00, wr_cnt} - {2'b00, adv_n};
                pc_q    <= pc_q + {60'd0, adv_n, 1'b0};
                if (ack_write) begin
                    fetch_addr_q <= fetch_addr_q + 64'd8;
                    skip_q       <= 2'd0;
                end
            end

            unique case (state_q)
                StIdle: begin
                    // Issuing only at count <= 12 guarantees room for a full word.
                    if (!redirect && count_q <= 5'd12) begin
                        state_q <= StReq;
                        req_q   <= 1'b1;
                        addr_q  <= fetch_addr_q;
                    end
                end
                StReq: begin
                    if (imem_ack) begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                    end else if (redirect) begin
                        state_q <= StDiscard;
                    end
                end
                StDiscard: begin
                    if (imem_ack) begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for advances plus hand sequences for redirects.
module tb_fetch_unit;
    logic        clk;
    logic        rst;
    logic [63:0] fe_inst;
    logic        fe_inst_valid;
    logic [63:0] fe_pc;
    logic        fe_advance16;
    logic        fe_advance32;
    logic        fe_advance64;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [63:0] imem_data;

    int total = 0;
    int bad = 0;
    int lat = 1;
    int waited = 0;
    bit manual_mode = 1'b0;
    bit man_ack = 1'b0;
    logic [63:0] ack_log [$];

    fetch_unit #(.RESET_PC(64'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .fe_inst       (fe_inst),
        .fe_inst_valid (fe_inst_valid),
        .fe_pc         (fe_pc),
        .fe_advance16  (fe_advance16),
        .fe_advance32  (fe_advance32),
        .fe_advance64  (fe_advance64),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Halfword stored at byte address a; unique over the address ranges used here.
    function automatic logic [15:0] hw(input logic [63:0] a);
        return 16'h5000 + a[15:0];
    endfunction

    // Four consecutive halfwords starting at a: both memory words and expected windows.
    function automatic logic [63:0] words_at(input logic [63:0] a);
        return {hw(a), hw(a + 64'd2), hw(a + 64'd4), hw(a + 64'd6)};
    endfunction

    // Memory responder: acks 'lat' cycles after the request is seen, or as told in manual mode.
    initial begin
        imem_ack = 1'b0;
        imem_data = 64'd0;
        forever begin
            @(negedge clk);
            if (manual_mode) begin
                imem_ack = man_ack;
                imem_data = words_at(imem_addr);
                waited = 0;
            end else if (imem_req && waited >= lat) begin
                imem_ack = 1'b1;
                imem_data = words_at(imem_addr);
                waited = 0;
            end else begin
                imem_ack = 1'b0;
                waited = imem_req ? waited + 1 : 0;
            end
            if (imem_ack) ack_log.push_back(imem_addr);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n = 0;
        while (!fe_inst_valid && n < limit) begin
            step();
            n++;
        end
        total++;
        if (!fe_inst_valid) begin
            bad++;
            $display("FAIL %s: fe_inst_valid=0 want 1 within %0d cycles", name, limit);
        end
    endtask

    task automatic wait_req(input string name, input int limit);
        int n = 0;
        while (!imem_req && n < limit) begin
            step();
            n++;
        end
        total++;
        if (!imem_req) begin
            bad++;
            $display("FAIL %s: imem_req=0 want 1 within %0d cycles", name, limit);
        end
    endtask

    // Returns just after the edge that consumed an ack.
    task automatic wait_ack(input string name, input int limit);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < limit) begin
            step();
            seen = imem_ack;
            n++;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: imem_ack=0 want 1 within %0d cycles", name, limit);
        end
    endtask

    typedef struct {
        logic        a16;
        logic        a32;
        logic        a64;
        logic [63:0] pc;
    } vec_t;

    vec_t vecs [12];
    logic [63:0] stale;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 64'h02};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 64'h06};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 64'h0E};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 64'h10};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 64'h18};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 64'h20};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 64'h24};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 64'h24};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 64'h2C};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 64'h34};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 64'h38};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 64'h3A};

        rst = 1'b1;
        fe_advance16 = 1'b0;
        fe_advance32 = 1'b0;
        fe_advance64 = 1'b0;
        redirect = 1'b0;
        redirect_pc = 64'd0;

        // Reset state
        step();
        step();
        chk("reset fe_pc", fe_pc, 64'h0);
        chk("reset valid", 64'(fe_inst_valid), 64'd0);
        chk("reset imem_req", 64'(imem_req), 64'd0);
        chk("reset imem_addr", imem_addr, 64'h0);
        rst = 1'b0;
        step();
        chk("first req", 64'(imem_req), 64'd1);
        chk("first addr", imem_addr, 64'h0);

        // Fill with no advance: exactly four words, then idle
        repeat (20) step();
        chk("fill ack count", 64'(ack_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("fill addr", (i < ack_log.size()) ? ack_log[i] : 64'hFFFF_FFFF_FFFF_FFFF,
                64'(i * 8));
        end
        chk("fill req idle", 64'(imem_req), 64'd0);
        chk("fill fe_pc", fe_pc, 64'h0);
        chk("fill valid", 64'(fe_inst_valid), 64'd1);
        chk("fill window", fe_inst, words_at(64'h0));

        // Advance vectors
        for (int i = 0; i < 12; i++) begin
            wait_valid("vec pre-valid", 30);
            fe_advance16 = vecs[i].a16;
            fe_advance32 = vecs[i].a32;
            fe_advance64 = vecs[i].a64;
            step();
            fe_advance16 = 1'b0;
            fe_advance32 = 1'b0;
            fe_advance64 = 1'b0;
            chk("vec fe_pc", fe_pc, vecs[i].pc);
            wait_valid("vec valid", 30);
            chk("vec window", fe_inst, words_at(vecs[i].pc));
        end

        // Redirect to 0x1006 from idle
        repeat (20) step();
        redirect = 1'b1;
        redirect_pc = 64'h1006;
        step();
        redirect = 1'b0;
        chk("redir fe_pc", fe_pc, 64'h1006);
        chk("redir valid", 64'(fe_inst_valid), 64'd0);
        chk("redir req low", 64'(imem_req), 64'd0);
        step();
        chk("redir req", 64'(imem_req), 64'd1);
        chk("redir addr", imem_addr, 64'h1000);
        step();
        step();
        chk("redir count1 valid", 64'(fe_inst_valid), 64'd0);
        step();
        chk("redir next addr", imem_addr, 64'h1008);
        wait_valid("redir fill", 30);
        chk("redir window", fe_inst, words_at(64'h1006));
        chk("redir fe_pc hold", fe_pc, 64'h1006);

        // Redirect while a slow request is outstanding
        repeat (20) step();
        lat = 5;
        fe_advance64 = 1'b1;
        step();
        fe_advance64 = 1'b0;
        wait_req("slow req", 20);
        stale = imem_addr;
        redirect = 1'b1;
        redirect_pc = 64'h2002;
        step();
        redirect = 1'b0;
        chk("discard fe_pc", fe_pc, 64'h2002);
        chk("discard valid", 64'(fe_inst_valid), 64'd0);
        chk("discard req held", 64'(imem_req), 64'd1);
        chk("discard addr held", imem_addr, stale);
        wait_ack("discard ack", 20);
        chk("discard req drop", 64'(imem_req), 64'd0);
        wait_req("post-discard req", 10);
        chk("post-discard addr", imem_addr, 64'h2000);
        wait_valid("post-discard fill", 80);
        chk("post-discard window", fe_inst, words_at(64'h2002));
        chk("post-discard fe_pc", fe_pc, 64'h2002);
        lat = 1;

        // Redirect, ack and advance64 in the same cycle
        repeat (20) step();
        manual_mode = 1'b1;
        man_ack = 1'b0;
        fe_advance64 = 1'b1;
        step();
        fe_advance64 = 1'b0;
        wait_req("same-cycle req", 10);
        man_ack = 1'b1;
        redirect = 1'b1;
        redirect_pc = 64'h3000;
        fe_advance64 = 1'b1;
        step();
        man_ack = 1'b0;
        redirect = 1'b0;
        fe_advance64 = 1'b0;
        chk("same-cycle fe_pc", fe_pc, 64'h3000);
        chk("same-cycle valid", 64'(fe_inst_valid), 64'd0);
        chk("same-cycle req", 64'(imem_req), 64'd0);
        step();
        chk("same-cycle new req", 64'(imem_req), 64'd1);
        chk("same-cycle new addr", imem_addr, 64'h3000);
        manual_mode = 1'b0;
        wait_valid("same-cycle fill", 30);
        chk("same-cycle window", fe_inst, words_at(64'h3000));
        chk("same-cycle fe_pc hold", fe_pc, 64'h3000);

        // Advance ignored while only two halfwords are buffered
        repeat (20) step();
        manual_mode = 1'b1;
        man_ack = 1'b0;
        redirect = 1'b1;
        redirect_pc = 64'h4004;
        step();
        redirect = 1'b0;
        chk("low fe_pc", fe_pc, 64'h4004);
        step();
        chk("low req", 64'(imem_req), 64'd1);
        chk("low addr", imem_addr, 64'h4000);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        chk("low valid", 64'(fe_inst_valid), 64'd0);
        fe_advance16 = 1'b1;
        step();
        fe_advance16 = 1'b0;
        chk("low adv16 ignored", fe_pc, 64'h4004);
        fe_advance32 = 1'b1;
        fe_advance64 = 1'b1;
        step();
        fe_advance32 = 1'b0;
        fe_advance64 = 1'b0;
        chk("low adv64 ignored", fe_pc, 64'h4004);
        manual_mode = 1'b0;
        wait_valid("low fill", 30);
        chk("low window", fe_inst, words_at(64'h4004));
        chk("low fe_pc hold", fe_pc, 64'h4004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the Raisin64 pipeline, sitting directly upstream of decode. Fetches aligned 64-bit words from instruction memory into a 16-halfword circular buffer and presents a 64-bit instruction window starting at the current PC. Decode consumes 16-, 32- or 64-bit instructions through the advance strobes. Branch redirects flush the buffer and restart fetch at any halfword-aligned address.

## Interface

Parameters:
- RESET_PC, 64'h0, PC after reset (halfword aligned; bit 0 ignored)

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- fe_inst  out  64  instruction window; halfword at pc in [63:48], pc+2 in [47:32], pc+4 in [31:16], pc+6 in [15:0]
- fe_inst_valid  out  1  at least 4 halfwords buffered; window fully valid
- fe_pc  out  64  byte address of the halfword in fe_inst[63:48]
- fe_advance16  in  1  consume 1 halfword
- fe_advance32  in  1  consume 2 halfwords
- fe_advance64  in  1  consume 4 halfwords
- redirect  in  1  flush and restart at redirect_pc
- redirect_pc  in  64  new PC (bit 0 ignored)
- imem_req  out  1  read request
- imem_addr  out  64  read address, 8-byte aligned
- imem_ack  in  1  read complete; imem_data valid this cycle
- imem_data  in  64  read data; byte addr+0 in [63:56]

## Operation

- Storage: 16 × 16-bit halfword slots, 4-bit read pointer rd, 4-bit write pointer wr, 5-bit count (0..16). Pointers wrap modulo 16.
- fe_inst = slots[rd], slots[rd+1], slots[rd+2], slots[rd+3] (mod 16). Combinational from registers. Don't-care when fe_inst_valid=0.
- fe_inst_valid = (count >= 4). Combinational from the count register.
- Advance: honoured only when fe_inst_valid=1; otherwise ignored. Priority 64 > 32 > 16 if several are high. Takes n = 4/2/1 halfwords: rd += n, fe_pc += 2n (mod 2^64).
- Fetch FSM states:
  - IDLE: go to REQ when count <= 12. Drive imem_req=1 and imem_addr=fetch_addr.
  - REQ: hold imem_req and imem_addr stable until imem_ack. On ack, write halfwords into the buffer, set fetch_addr += 8, and go to IDLE.
  - DISCARD: imem_req stays high until imem_ack. Data is dropped. Then go to IDLE.
- Write on ack: normally 4 halfwords at wr. For the first word after a redirect, skip redirect_pc[2:1] leading halfwords and write 4 − skip.
- Simultaneous ack and advance in one cycle: count_next = count + written − n.
- Redirect has priority over advance and over ack data:
  - rd = wr = count = 0.
  - fe_pc = {redirect_pc[63:1], 1'b0}.
  - fetch_addr = {redirect_pc[63:3], 3'b0}.
  - skip = redirect_pc[2:1].
  - If in REQ with no imem_ack this cycle, go to DISCARD.
  - If imem_ack arrives in the redirect cycle, drop its data and go to IDLE.
  - If already in DISCARD, stay in DISCARD.
- A new redirect during DISCARD replaces the pending fetch target.
- At most one request is outstanding. Because requests are issued only at count <= 12, the buffer never overflows.

## Timing

- Reset (rst=1 at an edge) sets:
  - state=IDLE, imem_req=0, imem_addr={RESET_PC[63:3],3'b0}
  - fe_pc={RESET_PC[63:1],1'b0}, count=0, fe_inst_valid=0
  - skip=RESET_PC[2:1]
- Reset mid-request abandons the transaction. Any imem_ack arriving afterwards while in IDLE is ignored.
- First cycle after reset release: state=IDLE. imem_req=1 in the following cycle.
- Ack in cycle N: data is written at edge N→N+1. fe_inst_valid rises in N+1 if count >= 4.
- Earliest next request after an ack is cycle N+2 (one IDLE cycle).
- Redirect in cycle N: fe_inst_valid=0 and the new fe_pc in N+1. If not discarding, imem_req with the new address rises in N+2.
- imem_ack while imem_req=0 is ignored.

## Test plan

- Reset with RESET_PC=0, memory returning word k = 64'h(k)(k)(k)(k) halfword pattern, ack one cycle after req, no advance → 4 words fetched (addr 0,8,10,18), count=16, imem_req stays 0; fe_pc=0, window = word 0.
- Advance sequence 16,32,64,16 with continuous ack → fe_pc = 2,6,0xE,0x10; window contents track halfword order across word boundaries; rd wraps past 15 with no corruption.
- Redirect to 0x1006 → first request addr 0x1000, only halfword 3 is stored; count=1, fe_inst_valid=0 until the next word 0x1008 arrives; then window = hw(0x1006), hw(0x1008..0x100C); fe_pc=0x1006.
- Redirect while in REQ with ack delayed 5 cycles → stale data dropped; imem_req stays high until that ack, then the next request goes to the redirect address; no stale halfword ever appears in fe_inst.
- Redirect in the same cycle as imem_ack and an advance64 → ack data and advance both ignored; count=0 and fe_pc=redirect_pc next cycle.
- Advance asserted with count=2 → ignored; fe_pc and rd unchanged. fe_advance16+fe_advance64 together with valid window → fe_pc += 8.
